decoder_2x4_strobe: RTL and testbench

Registered 2-to-4 line decoder with a valid/ready input handshake and a programmable output hold time. It is the receive-side counterpart of the 4-to-2 encoder: a 2-bit code is accepted, and the matching one-hot output line is driven for `HOLD_CYCLES` clock cycles. Saturating per-line hit counters are provided for debug and for bench checking.

---
 rtl/decoder_pkg.sv | 24 ++
 rtl/decoder_2x4_strobe_sat_counter.sv | 28 ++
 rtl/decoder_2x4_strobe.sv | 103 ++++++++++
 tb/tb_decoder_2x4_strobe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared constants, FSM state type and the one-hot helper for the
// registered 2-to-4 strobe decoder.
//   CODE_W  width of the encoded line index
//   OUT_W   number of decoded output lines
package decoder_pkg;

  localparam int CODE_W = 2;
  localparam int OUT_W  = 4;

  typedef enum logic {
    DEC_IDLE = 1'b0,
    DEC_HOLD = 1'b1
  } dec_state_t;

  // One-hot expansion of a line index.
  function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_2x4_strobe_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears q
//   clr    synchronous clear, wins over inc in the same cycle
//   inc    count one event
//   q      current count
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_2x4_strobe.sv
// decoder_2x4_strobe
// Registered 2-to-4 decoder. An accepted code drives its one-hot line for
// HOLD_CYCLES cycles; per-line saturating hit counters record decodes.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   code is offered this cycle
//   in_ready   a code can be accepted this cycle
//   code       encoded line index 0..3
//   en         decode enable, sampled with the accepted code
//   cnt_clr    synchronous clear of all hit counters
//   out        one-hot strobe, zero when idle
//   out_valid  high whenever out is non-zero
//   hit_cnt    packed counters, line i at [i*CNT_W +: CNT_W]
//   fsm_state  current FSM state, for debug observation
//
// Handshake: a code is taken on a rising edge where in_valid && in_ready.
// in_ready is combinational and never depends on in_valid; the sender must
// hold code/en stable until the transfer happens.
module decoder_2x4_strobe
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CODE_W-1:0]      code,
  input  logic                   en,
  input  logic                   cnt_clr,
  output logic [OUT_W-1:0]       out,
  output logic                   out_valid,
  output logic [OUT_W*CNT_W-1:0] hit_cnt,
  output dec_state_t             fsm_state
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  dec_state_t       state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             accept;

  // Ready in IDLE, and on the final hold cycle so a new code can follow
  // without a zero gap on out.
  assign in_ready = (state_q == DEC_IDLE) || (hold_cnt_q == 8'd0);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DEC_IDLE;
      hold_cnt_q <= 8'd0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      out_q      <= out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    out_d      = out_q;
    if (accept) begin
      if (en) begin
        state_d    = DEC_HOLD;
        hold_cnt_d = HOLD_LOAD;
        out_d      = onehot(code);
      end else begin
        // Disabled code is consumed but produces no strobe.
        state_d    = DEC_IDLE;
        hold_cnt_d = 8'd0;
        out_d      = '0;
      end
    end else if (state_q == DEC_HOLD) begin
      if (hold_cnt_q != 8'd0) begin
        hold_cnt_d = hold_cnt_q - 8'd1;
      end else begin
        state_d = DEC_IDLE;
        out_d   = '0;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = |out_q;
  assign fsm_state = state_q;

  for (genvar i = 0; i < OUT_W; i++) begin : g_cnt
    logic inc;
    assign inc = accept && en && (code == CODE_W'(i));
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (inc),
      .q     (hit_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_decoder_2x4_strobe.sv
module tb_decoder_2x4_strobe;
  import decoder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT: HOLD_CYCLES=4, CNT_W=8
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  code = 2'd0;
  logic        en = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [3:0]  dout;
  logic        out_valid;
  logic [31:0] hit_cnt;
  dec_state_t  fsm_state;

  // saturation DUT: HOLD_CYCLES=1, CNT_W=2
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [1:0]  s_code = 2'd0;
  logic        s_en = 1'b0;
  logic        s_clr = 1'b0;
  logic [3:0]  s_out;
  logic        s_out_valid;
  logic [7:0]  s_hit;
  dec_state_t  s_state;

  decoder_2x4_strobe #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .en(en), .cnt_clr(cnt_clr), .out(dout),
    .out_valid(out_valid), .hit_cnt(hit_cnt), .fsm_state(fsm_state)
  );

  decoder_2x4_strobe #(.HOLD_CYCLES(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready),
    .code(s_code), .en(s_en), .cnt_clr(s_clr), .out(s_out),
    .out_valid(s_out_valid), .hit_cnt(s_hit), .fsm_state(s_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [3:0] exp_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input int line, input logic [7:0] exp);
    check($sformatf("hit_cnt[%0d]", line), 32'(hit_cnt[line*8 +: 8]), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_out", 32'(dout), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);
    check("reset_hit_cnt", hit_cnt, 32'h0);
    check("reset_state", 32'(fsm_state), 32'(DEC_IDLE));
    check("reset_sat_hit", 32'(s_hit), 32'h0);

    // Single decode: code 2 held for 4 cycles
    step();
    in_valid = 1'b1; code = 2'd2; en = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_hit2", 32'(hit_cnt[16 +: 8]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("single_out_c%0d", i), 32'(dout), 32'(4'b0100));
      check($sformatf("single_ready_c%0d", i), 32'(in_ready), (i == 3) ? 32'd1 : 32'd0);
      check($sformatf("single_state_c%0d", i), 32'(fsm_state), 32'(DEC_HOLD));
      step();
    end
    check("single_out_end", 32'(dout), 32'h0);
    check("single_out_valid_end", 32'(out_valid), 32'h0);
    check("single_state_end", 32'(fsm_state), 32'(DEC_IDLE));

    // Streaming 0,1,2,3 with in_valid held high, no gaps
    in_valid = 1'b1; code = 2'd0; en = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("stream_out_%0d_%0d", c, i), 32'(dout), 32'(exp_oh[c]));
        check($sformatf("stream_valid_%0d_%0d", c, i), 32'(out_valid), 32'd1);
        if (i == 3) begin
          if (c < 3) code = 2'(c + 1);
          else in_valid = 1'b0;
        end
        step();
      end
    end
    check("stream_out_end", 32'(dout), 32'h0);
    check_cnt(0, 8'd1);
    check_cnt(1, 8'd1);
    check_cnt(2, 8'd2);
    check_cnt(3, 8'd1);

    // Disabled code is consumed and dropped
    in_valid = 1'b1; code = 2'd3; en = 1'b0;
    step();
    in_valid = 1'b0;
    check("disabled_out", 32'(dout), 32'h0);
    check("disabled_ready", 32'(in_ready), 32'd1);
    check("disabled_state", 32'(fsm_state), 32'(DEC_IDLE));
    check_cnt(3, 8'd1);

    // Stalled input: code 1 offered mid-HOLD of code 0
    in_valid = 1'b1; code = 2'd0; en = 1'b1;
    step();
    check("stall_first", 32'(dout), 32'(4'b0001));
    code = 2'd1;
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("stall_hold_%0d", i), 32'(dout), 32'(4'b0001));
      check_cnt(1, 8'd1);
    end
    check("stall_ready_final", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("stall_taken", 32'(dout), 32'(4'b0010));
    check_cnt(0, 8'd2);
    check_cnt(1, 8'd2);
    repeat (4) step();
    check("stall_idle", 32'(dout), 32'h0);

    // Saturation / clear on CNT_W=2, HOLD_CYCLES=1 instance
    s_valid = 1'b1; s_code = 2'd0; s_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("sat_out_%0d", k), 32'(s_out), 32'(4'b0001));
      check($sformatf("sat_ready_%0d", k), 32'(s_ready), 32'd1);
      check($sformatf("sat_cnt_%0d", k), 32'(s_hit[1:0]), (k < 3) ? 32'(k) : 32'd3);
    end
    s_clr = 1'b1;
    step();
    check("sat_clr_priority", 32'(s_hit[1:0]), 32'd0);
    check("sat_clr_out", 32'(s_out), 32'(4'b0001));
    s_clr = 1'b0; s_code = 2'd3;
    step();
    check("sat_after_clr0", 32'(s_hit[1:0]), 32'd0);
    check("sat_line3", 32'(s_hit[7:6]), 32'd1);
    check("sat_line3_out", 32'(s_out), 32'(4'b1000));
    s_valid = 1'b0;
    step();
    check("sat_idle", 32'(s_out), 32'h0);
    check("sat_idle_valid", 32'(s_out_valid), 32'h0);

    // Reset mid-HOLD
    in_valid = 1'b1; code = 2'd3; en = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("rst_mid_before", 32'(dout), 32'(4'b1000));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out", 32'(dout), 32'h0);
    check("rst_mid_out_valid", 32'(out_valid), 32'h0);
    check("rst_mid_hit", hit_cnt, 32'h0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; code = 2'd1; en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    in_valid = 1'b0;
    check("rst_first_accept", 32'(dout), 32'(4'b0010));
    check_cnt(1, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
